// File: rtl/clave_hit_judge_if.sv
// Signal bundle between the phrase counter / player key and the clave hit judge.
interface clave_hit_judge_if;
    logic        go;
    logic [12:0] count;
    logic        key;
    logic        cue;
    logic        hit;
    logic        miss;
    logic [2:0]  beat_idx;
    logic [3:0]  score;
    logic        done;

    modport master (
        output go, count, key,
        input  cue, hit, miss, beat_idx, score, done
    );

    modport slave (
        input  go, count, key,
        output cue, hit, miss, beat_idx, score, done
    );
endinterface

// File: rtl/clave_hit_judge.sv
// Judges key presses against the 3-2 son-clave beat targets and keeps a phrase score.
// Optional macro CLAVE_EARLY_PENALTY_EN: stray presses while armed pulse miss and cost one point.
module clave_hit_judge #(
    parameter logic [12:0] STEP   = 13'd400,
    parameter logic [12:0] OFFSET = 13'd200,
    parameter logic [12:0] WINDOW = 13'd40
) (
    input  logic               clk,
    input  logic               reset,
    clave_hit_judge_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [3:0]  score;
    logic        done;
    logic        cue_q;
    logic        hit_q;
    logic        miss_q;
    logic        key_prev;
    logic [12:0] count_prev;

    logic [12:0] t;
    logic [12:0] hi;
    logic [12:0] lo;
    logic        press;
    logic        late;
    logic        in_win;

    function automatic logic [12:0] target(input logic [2:0] i);
        case (i)
            3'd0:    target = OFFSET;
            3'd1:    target = OFFSET + 13'd3  * STEP;
            3'd2:    target = OFFSET + 13'd6  * STEP;
            3'd3:    target = OFFSET + 13'd10 * STEP;
            3'd4:    target = OFFSET + 13'd12 * STEP;
            default: target = '0;
        endcase
    endfunction

    // Low bound clamps at zero so an early target never wraps the window.
    always_comb begin
        t      = target(idx);
        hi     = t + WINDOW;
        lo     = (t >= WINDOW) ? (t - WINDOW) : '0;
        press  = bus.key && !key_prev;
        late   = bus.count > hi;
        in_win = bus.count >= lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            score      <= '0;
            done       <= 1'b0;
            cue_q      <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            key_prev   <= 1'b0;
            count_prev <= '0;
        end else begin
            key_prev   <= bus.key;
            count_prev <= bus.count;
            cue_q      <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            if (bus.go) begin
                state <= ARMED;
                idx   <= '0;
                score <= '0;
                done  <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        cue_q <= (bus.count == t) && (count_prev != t);
                        if (late || (press && in_win)) begin
                            miss_q <= late;
                            hit_q  <= !late;
                            if (!late && score != 4'd15)
                                score <= score + 4'd1;
                            if (idx == 3'd4) begin
                                state <= DONE;
                                idx   <= 3'd5;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
`ifdef CLAVE_EARLY_PENALTY_EN
                        else if (press) begin
                            miss_q <= 1'b1;
                            if (score != 4'd0)
                                score <= score - 4'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cue      = cue_q;
    assign bus.hit      = hit_q;
    assign bus.miss     = miss_q;
    assign bus.beat_idx = idx;
    assign bus.score    = score;
    assign bus.done     = done;

endmodule

// File: tb/tb_clave_hit_judge.sv
// Randomised and directed bench for clave_hit_judge against a behavioural phrase model.
module tb_clave_hit_judge;

    logic clk = 1'b0;
    logic reset;
    clave_hit_judge_if bus();

    clave_hit_judge #(.STEP(13'd400), .OFFSET(13'd200), .WINDOW(13'd40)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: beat position 0..4 armed, 5 finished.
    int steps[5] = '{0, 3, 6, 10, 12};
    bit m_on;
    int m_idx, m_score, m_prev_cnt;
    bit m_prev_key, e_cue, e_hit, e_miss;

    int n_hit, n_cue, n_miss;
    int miss_at[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tgt(input int i);
        return 200 + steps[i] * 400;
    endfunction

    task automatic model(input bit r, input bit g, input int c, input bit k);
        bit press;
        int t, lo, hi;
        press  = k && !m_prev_key;
        e_cue  = 0;
        e_hit  = 0;
        e_miss = 0;
        if (r) begin
            m_on = 0; m_idx = 0; m_score = 0; m_prev_cnt = 0; m_prev_key = 0;
            return;
        end
        if (g) begin
            m_on = 1; m_idx = 0; m_score = 0;
        end else if (m_on && m_idx < 5) begin
            t  = tgt(m_idx);
            lo = (t - 40 < 0) ? 0 : t - 40;
            hi = t + 40;
            e_cue = (c == t) && (m_prev_cnt != t);
            if (c > hi) begin
                e_miss = 1;
                m_idx++;
            end else if (press && c >= lo) begin
                e_hit = 1;
                if (m_score < 15) m_score++;
                m_idx++;
            end else if (press) begin
`ifdef CLAVE_EARLY_PENALTY_EN
                e_miss = 1;
                if (m_score > 0) m_score--;
`endif
            end
        end
        m_prev_cnt = c;
        m_prev_key = k;
    endtask

    function automatic logic [10:0] outs_dut();
        return {bus.cue, bus.hit, bus.miss, bus.beat_idx, bus.score, bus.done};
    endfunction

    task automatic apply(input bit r, input bit g, input int c, input bit k);
        logic [10:0] exp;
        reset     = r;
        bus.go    = g;
        bus.count = 13'(c);
        bus.key   = k;
        @(posedge clk);
        model(r, g, c, k);
        #1;
        exp = {e_cue, e_hit, e_miss, 3'(m_idx), 4'(m_score), (m_on && m_idx == 5)};
        check("outs", 32'(outs_dut()), 32'(exp));
        if (bus.hit)  n_hit++;
        if (bus.cue)  n_cue++;
        if (bus.miss) begin
            n_miss++;
            miss_at.push_back(c);
        end
    endtask

    function automatic bit is_tgt(input int c);
        for (int i = 0; i < 5; i++)
            if (tgt(i) == c) return 1;
        return 0;
    endfunction

    // p = -1: press at every target, p = -2: never, else press at count p.
    task automatic sweep(input int from, input int to, input int p);
        bit k;
        for (int c = from; c <= to; c++) begin
            k = (p == -1) ? is_tgt(c) : (p == c);
            apply(0, 0, c, k);
        end
    endtask

    task automatic clr_counts();
        n_hit = 0; n_cue = 0; n_miss = 0;
        miss_at.delete();
    endtask

    initial begin
        int c, r, inc;
        bit k;
        int exp_miss_at[5] = '{241, 1441, 2641, 4241, 5041};

        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        check("reset_outs", 32'(outs_dut()), 32'd0);

        // Perfect phrase
        apply(0, 1, 0, 0);
        clr_counts();
        sweep(0, 6600, -1);
        check("perfect_hits", n_hit, 5);
        check("perfect_cues", n_cue, 5);
        check("perfect_score", bus.score, 5);
        check("perfect_done", bus.done, 1);
        check("perfect_idx", bus.beat_idx, 5);

        // Silent phrase
        apply(0, 1, 0, 0);
        clr_counts();
        sweep(0, 6600, -2);
        check("silent_nmiss", miss_at.size(), 5);
        for (int i = 0; i < 5 && i < miss_at.size(); i++)
            check("silent_miss_at", miss_at[i], exp_miss_at[i]);
        check("silent_score", bus.score, 0);
        check("silent_done", bus.done, 1);

        // Window edges
        apply(0, 1, 0, 0);
        sweep(0, 160, 160);
        check("edge160_hit", bus.hit, 1);
        apply(0, 1, 0, 0);
        sweep(0, 240, 240);
        check("edge240_hit", bus.hit, 1);
        apply(0, 1, 0, 0);
        sweep(0, 159, 159);
        check("edge159_hit", bus.hit, 0);
`ifdef CLAVE_EARLY_PENALTY_EN
        check("edge159_miss", bus.miss, 1);
`else
        check("edge159_miss", bus.miss, 0);
`endif
        check("edge159_score", bus.score, 0);

        // Paused count at target and held key
        apply(0, 1, 0, 0);
        sweep(0, 1399, -2);
        clr_counts();
        repeat (10) apply(0, 0, 1400, 1);
        check("hold_cue", n_cue, 1);
        for (int cc = 1401; cc <= 1450; cc++) apply(0, 0, cc, 1);
        check("hold_hits", n_hit, 1);

        // go beats a simultaneous press
        apply(0, 1, 0, 0);
        sweep(0, 1399, 200);
        apply(0, 1, 1400, 1);
        check("go_score", bus.score, 0);
        check("go_idx", bus.beat_idx, 0);
        check("go_hit", bus.hit, 0);

        // reset mid-phrase, go ignored on the same edge
        apply(0, 1, 0, 0);
        sweep(0, 3000, -1);
        check("mid_score", bus.score, 3);
        apply(1, 1, 3000, 0);
        check("mid_reset_outs", 32'(outs_dut()), 32'd0);
        apply(0, 0, 200, 0);
        apply(0, 0, 200, 1);
        apply(0, 0, 201, 0);
        check("idle_outs", 32'(outs_dut()), 32'd0);

        // Randomised phrases with pauses, skips, stray presses, go and reset
        for (int ph = 0; ph < 12; ph++) begin
            apply(0, 1, 0, 0);
            c = 0;
            k = 0;
            for (int cyc = 0; cyc < 3000 && c <= 6600; cyc++) begin
                r = $urandom_range(0, 999);
                if ($urandom_range(0, 5) == 0) k = ~k;
                if (r < 3) begin
                    apply(1, $urandom_range(0, 1), c, k);
                    apply(0, 1, 0, k);
                    c = 0;
                end else if (r < 6) begin
                    apply(0, 1, c, k);
                    c = 0;
                end else begin
                    apply(0, 0, c, k);
                    inc = (r < 25) ? 700 : (r < 300) ? 0 : int'($urandom_range(1, 25));
                    c = c + inc;
                    if (c > 6600) c = 6600 + 1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clave_hit_judge.md
# clave_hit_judge

Consumes the 13-bit phrase count from the clave phrase counter and judges player key presses against a fixed 3-2 son-clave pattern of five beats. For each beat it emits a cue pulse when the count reaches the beat, then a one-cycle `hit` or `miss` verdict. It keeps a running score and flags when the phrase is finished. It sits between the phrase counter and the display/score logic.

## Interface
- `STEP`, 13'd400: counts per sixteenth step.
- `OFFSET`, 13'd200: count of step 0.
- `WINDOW`, 13'd40: half-width of the hit window, in counts.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; overrides all other inputs.
- `go`  in  1  restart phrase; same cycle the counter clears to 0.
- `count`  in  13  phrase count from the counter (0..6600, may hold while paused).
- `key`  in  1  player key level, already synchronised to `clk`.
- `cue`  out  1  one-cycle pulse when `count` arrives at the current beat target.
- `hit`  out  1  one-cycle pulse: current beat hit in window.
- `miss`  out  1  one-cycle pulse: current beat missed (or stray press, see Configuration).
- `beat_idx`  out  3  index of beat being judged, 0..5 (5 = all judged).
- `score`  out  4  hits this phrase, saturating.
- `done`  out  1  high once all five beats are judged.

## Operation
- Pattern steps: 0, 3, 6, 10, 12. Target t_i = OFFSET + step_i*STEP, i.e. 200, 1400, 2600, 4200, 5000 with defaults. Targets come from a fixed internal table. All compare arithmetic is unsigned 13-bit. The window low bound is clamped at 0 (no underflow).
- Press = `key`=1 this cycle and `key`=0 at the previous edge. A `key_prev` register is kept for this.
- States:
  - IDLE: after reset. Ignores `count` and `key`.
  - `go` → ARMED with idx=0, score=0.
  - ARMED: evaluated each cycle against t = t_idx, in priority order:
    1. `count` > t+WINDOW: pulse `miss`, then idx+1.
    2. Else if press and t−WINDOW ≤ `count` ≤ t+WINDOW (inclusive): pulse `hit`, score+1, then idx+1.
    3. Else if press: stray press. Ignored in the base build.
  - Advancing from idx=4 goes to DONE.
  - DONE: `done`=1, idx=5. Presses are ignored and `count` is ignored.
  - `go` from any state → ARMED, idx=0, score=0, and clears all pulses.
- `cue`: pulses when in ARMED, `count` == t_idx, and the previous-cycle `count` ≠ t_idx. A paused count held at the target gives exactly one cue.
- `count` jumping past a whole window (e.g. counter skip) produces one `miss` per cycle, one beat per cycle, until the current window is no longer stale.
- Score saturates at 15. Score is never reachable above 5 in the base build.

## Timing
- All outputs are registered. Reset values: `cue`=`hit`=`miss`=0, `beat_idx`=0, `score`=0, `done`=0, state IDLE, `key_prev`=0, previous count=0.
- A verdict is visible in the cycle after the edge that samples the qualifying `count`/`key`. `score`/`beat_idx` update on the same edge as the `hit`/`miss` pulse.
- At most one of `hit`/`miss` is asserted per cycle. `cue` may coincide with `hit`.
- `go` and a press in the same cycle: `go` wins and the press is discarded. `key_prev` still updates.
- `reset` mid-phrase: all state returns to reset values on that edge. A `go` in the same cycle is ignored.
- Second press in the same window: the first press scores. The second is judged against the next beat as a stray or early press.

## Configuration
- `CLAVE_EARLY_PENALTY_EN`:
  - Defined: a stray press in ARMED pulses `miss` and decrements `score`, saturating at 0. `beat_idx` does not advance.
  - Undefined: stray presses are silently ignored.

## Test plan
- Reset, `go`, sweep `count` 0→6600 by 1 with presses at counts 200, 1400, 2600, 4200, 5000 → five `hit` pulses and five `cue` pulses; then `score`=5, `done`=1, `beat_idx`=5.
- Same sweep with no presses → `miss` pulses at counts 241, 1441, 2641, 4241, 5041; `score`=0, `done`=1.
- Window edges: press at count 160 → `hit`. Press at 240 → `hit`. Press at 159 → no hit; without the macro no `miss`, with `CLAVE_EARLY_PENALTY_EN` a `miss` and score stays 0.
- Hold `count` at 1400 for 10 cycles → exactly one `cue`. Hold `key` high across the window → only one hit is scored.
- Press at count 200, then `go` on the same cycle as a press at 1400 → `score`=0, `beat_idx`=0, no `hit`.
- Assert `reset` at count 3000 with `score`=3 → next cycle all outputs 0, state IDLE. Presses are ignored until `go`.
